// File: rtl/goertzel_sum_pipe_pkg.sv
// Shared helpers for the Goertzel summing pipeline: width/level arithmetic,
// adder-tree geometry and output saturation bounds.
package goertzel_pkg;

  // Wide enough to hold the OUT_W bounds for any legal parameter set.
  localparam int SAT_BITS = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_lv(input int num_in);
    return clog2(num_in);
  endfunction

  // One guard bit beyond clog2 covers both growth and the negation of -2^(W-1).
  function automatic int calc_iw(input int w, input int num_in);
    return w + clog2(num_in) + 1;
  endfunction

  // Number of nodes held at a given tree level (level 0 = the operands).
  function automatic int node_cnt(input int num_in, input int level);
    int n;
    n = num_in;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

  // Position of a level's first node inside the flattened tree vector.
  function automatic int node_off(input int num_in, input int level);
    int off;
    off = 0;
    for (int l = 0; l < level; l++) off += node_cnt(num_in, l);
    return off;
  endfunction

  function automatic logic signed [SAT_BITS-1:0] sat_max(input int out_w);
    logic signed [SAT_BITS-1:0] one;
    one = 128'sd1;
    return (one <<< (out_w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_BITS-1:0] sat_min(input int out_w);
    logic signed [SAT_BITS-1:0] one;
    one = 128'sd1;
    return -(one <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/goertzel_sum_pipe_add2_reg.sv
// One node of the adder tree: registered two-input sum with its valid bit.
module add2_reg #(
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [IW-1:0] a_i,
  input  logic [IW-1:0] b_i,
  input  logic          vld_i,
  output logic [IW-1:0] sum_o,
  output logic          vld_o
);

  logic [IW-1:0] sum_d, sum_q;
  logic          vld_q;

  // Tree width already covers every possible sum, so a plain add never wraps.
  always_comb begin
    sum_d = a_i + b_i;
  end

  // Node register: frozen while en is low, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      sum_q <= sum_d;
      vld_q <= vld_i;
    end
  end

  assign sum_o = sum_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/goertzel_sum_pipe.sv
// Pipelined multi-operand signed adder: per-operand negate, registered
// pairwise tree, then range check with saturate/wrap and a sticky overflow.
import goertzel_pkg::*;

module goertzel_sum_pipe #(
  parameter int W      = 61,
  parameter int NUM_IN = 3,
  parameter int OUT_W  = 61,
  parameter int SAT_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [NUM_IN*W-1:0] in_data,
  input  logic [NUM_IN-1:0]   sub_mask,
  input  logic                clr_ovf,
  output logic [OUT_W-1:0]    y,
  output logic                out_valid,
  output logic                ovf
);

  localparam int IW    = calc_iw(W, NUM_IN);
  localparam int LV    = calc_lv(NUM_IN);
  localparam int NODES = node_off(NUM_IN, LV + 1);

  localparam logic signed [SAT_BITS-1:0] MAX_FULL = sat_max(OUT_W);
  localparam logic signed [SAT_BITS-1:0] MIN_FULL = sat_min(OUT_W);
  localparam logic signed [IW-1:0]       SAT_MAX  = MAX_FULL[IW-1:0];
  localparam logic signed [IW-1:0]       SAT_MIN  = MIN_FULL[IW-1:0];

  logic [NUM_IN*IW-1:0] s0_d, s0_q;
  logic                 s0_vld_q;
  logic signed [IW-1:0] ext_v;

  // All tree nodes, level by level, so every slice is driven and read exactly once.
  logic [NODES*IW-1:0]  tree;
  logic [LV:0]          lvl_vld;

  logic signed [IW-1:0] sum_w;
  logic                 in_range;
  logic [OUT_W-1:0]     y_d, y_q;
  logic                 out_valid_q;
  logic                 ovf_d, ovf_q;

  // Sign-extend each operand to tree width and negate the masked ones.
  always_comb begin
    s0_d  = '0;
    ext_v = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ext_v = IW'($signed(in_data[i*W +: W]));
      s0_d[i*IW +: IW] = sub_mask[i] ? -ext_v : ext_v;
    end
  end

  // Operand stage: sub_mask takes effect here, together with its data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_q     <= '0;
      s0_vld_q <= 1'b0;
    end else if (en) begin
      s0_q     <= s0_d;
      s0_vld_q <= in_valid;
    end
  end

  assign tree[0 +: NUM_IN*IW] = s0_q;
  assign lvl_vld[0]           = s0_vld_q;

  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    localparam int NI    = node_cnt(NUM_IN, l - 1);
    localparam int NO    = node_cnt(NUM_IN, l);
    localparam int OFF_I = node_off(NUM_IN, l - 1);
    localparam int OFF_O = node_off(NUM_IN, l);
    logic [NO-1:0] node_vld;

    for (genvar j = 0; j < NO; j++) begin : g_node
      logic [IW-1:0] b_op;
      if (2*j + 1 < NI) begin : g_pair
        assign b_op = tree[(OFF_I + 2*j + 1)*IW +: IW];
      end else begin : g_odd
        assign b_op = '0;
      end

      add2_reg #(.IW(IW)) u_add (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a_i   (tree[(OFF_I + 2*j)*IW +: IW]),
        .b_i   (b_op),
        .vld_i (lvl_vld[l-1]),
        .sum_o (tree[(OFF_O + j)*IW +: IW]),
        .vld_o (node_vld[j])
      );
    end

    assign lvl_vld[l] = &node_vld;
  end

  assign sum_w = $signed(tree[(NODES-1)*IW +: IW]);

  // Range check and result select; invalid slots leave y and ovf untouched.
  always_comb begin
    in_range = (sum_w <= SAT_MAX) && (sum_w >= SAT_MIN);
    y_d      = y_q;
    if (lvl_vld[LV]) begin
      if (in_range || SAT_EN == 0) y_d = sum_w[OUT_W-1:0];
      else if (sum_w > SAT_MAX)    y_d = SAT_MAX[OUT_W-1:0];
      else                         y_d = SAT_MIN[OUT_W-1:0];
    end
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (en && lvl_vld[LV] && !in_range) ovf_d = 1'b1;
  end

  // Output stage: y/out_valid follow en; the overflow flag also sees clr_ovf during stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        y_q         <= y_d;
        out_valid_q <= lvl_vld[LV];
      end
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_goertzel_sum_pipe.sv
// Bench for goertzel_sum_pipe (W=8, NUM_IN=3, OUT_W=8); a saturating and a
// wrapping instance share the same stimulus.
module tb_goertzel_sum_pipe;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, clr_ovf;
  logic [23:0] in_data;
  logic [2:0]  sub_mask;
  logic [7:0]  y_s, y_w;
  logic        ov_s, ov_w, of_s, of_w;

  always #5 clk = ~clk;

  goertzel_sum_pipe #(.W(8), .NUM_IN(3), .OUT_W(8), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .sub_mask(sub_mask), .clr_ovf(clr_ovf), .y(y_s), .out_valid(ov_s), .ovf(of_s)
  );

  goertzel_sum_pipe #(.W(8), .NUM_IN(3), .OUT_W(8), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .sub_mask(sub_mask), .clr_ovf(clr_ovf), .y(y_w), .out_valid(ov_w), .ovf(of_w)
  );

  typedef struct { bit v; int s; } ent_t;
  typedef struct { int a; int b; int c; bit [2:0] m; int ys; int yw; bit of; } vec_t;

  ent_t pipe[$];
  int   m_ys, m_yw;
  bit   m_ov, m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sb_s[$], sb_w[$];
  bit   collect  = 1'b0;
  int   got;
  vec_t tbl[9];

  function automatic int sat8(input int s);
    return (s > 127) ? 127 : (s < -128) ? -128 : s;
  endfunction

  function automatic int wrap8(input int s);
    int t;
    t = s & 255;
    return (t >= 128) ? t - 256 : t;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed integer sum, a delay of 3 enabled edges before the
  // output register, then saturate/wrap and sticky overflow (set beats clear).
  task automatic step(input bit r, input bit e, input bit v, input int a, input int b,
                      input int c, input bit [2:0] m, input bit clr);
    int   sum;
    ent_t ent;
    bit   set_f;
    rst      = r;
    en       = e;
    in_valid = v;
    in_data  = {c[7:0], b[7:0], a[7:0]};
    sub_mask = m;
    clr_ovf  = clr;
    sum   = (m[0] ? -a : a) + (m[1] ? -b : b) + (m[2] ? -c : c);
    set_f = 1'b0;
    if (!r) begin
      pipe.delete();
      repeat (3) pipe.push_back('{1'b0, 0});
      m_ys = 0; m_yw = 0; m_ov = 1'b0; m_ovf = 1'b0;
    end else begin
      if (e) begin
        pipe.push_back('{v, sum});
        ent  = pipe.pop_front();
        m_ov = ent.v;
        if (ent.v) begin
          m_ys  = sat8(ent.s);
          m_yw  = wrap8(ent.s);
          set_f = (ent.s > 127) || (ent.s < -128);
        end
      end
      if (set_f) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid_sat", int'(ov_s), int'(m_ov));
    chk("out_valid_wrap", int'(ov_w), int'(m_ov));
    chk("y_sat", int'($signed(y_s)), m_ys);
    chk("y_wrap", int'($signed(y_w)), m_yw);
    chk("ovf_sat", int'(of_s), int'(m_ovf));
    chk("ovf_wrap", int'(of_w), int'(m_ovf));
    if (collect && r && e && ov_s) begin
      got++;
      if (sb_s.size() > 0) begin
        chk("sb_y_sat", int'($signed(y_s)), sb_s.pop_front());
        chk("sb_y_wrap", int'($signed(y_w)), sb_w.pop_front());
      end else begin
        chk("sb_extra_result", 1, 0);
      end
    end
  endtask

  task automatic idle(input bit e, input bit clr);
    step(1'b1, e, 1'b0, 0, 0, 0, 3'b000, clr);
  endtask

  initial begin
    int lat, a, b, c;
    bit [2:0] m;

    tbl[0] = '{10, 20, 5, 3'b100, 25, 25, 1'b0};
    tbl[1] = '{100, 50, -20, 3'b000, 127, -126, 1'b1};
    tbl[2] = '{0, 0, -128, 3'b100, 127, -128, 1'b1};
    tbl[3] = '{-128, -128, -128, 3'b000, -128, -128, 1'b1};
    tbl[4] = '{-50, 30, -100, 3'b010, -128, 76, 1'b1};
    tbl[5] = '{127, -1, 0, 3'b010, 127, -128, 1'b1};
    tbl[6] = '{127, 0, 0, 3'b000, 127, 127, 1'b0};
    tbl[7] = '{-128, 0, 0, 3'b000, -128, -128, 1'b0};
    tbl[8] = '{-1, -1, -1, 3'b111, 3, 3, 1'b0};

    // Reset state
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    chk("reset_y", int'(y_s), 0);
    chk("reset_out_valid", int'(ov_s), 0);
    chk("reset_ovf", int'(of_s), 0);

    // Single operand sets from the table, 4-cycle latency, one-cycle out_valid
    for (int i = 0; i < 9; i++) begin
      idle(1'b1, 1'b1);
      chk("tbl_ovf_cleared", int'(of_s), 0);
      step(1'b1, 1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].m, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      chk("tbl_out_valid", int'(ov_s), 1);
      chk("tbl_y_sat", int'($signed(y_s)), tbl[i].ys);
      chk("tbl_y_wrap", int'($signed(y_w)), tbl[i].yw);
      chk("tbl_ovf", int'(of_s), int'(tbl[i].of));
      idle(1'b1, 1'b0);
      chk("tbl_out_valid_drop", int'(ov_s), 0);
      chk("tbl_y_hold", int'($signed(y_s)), tbl[i].ys);
    end

    // Latency across a 3-cycle stall
    idle(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1, 2, 3, 3'b000, 1'b0);
    repeat (3) idle(1'b0, 1'b0);
    lat = -1;
    for (int k = 5; k <= 20; k++) begin
      idle(1'b1, 1'b0);
      if (ov_s) begin
        lat = k;
        break;
      end
    end
    chk("stall_latency", lat, 7);
    chk("stall_result", int'($signed(y_s)), 6);
    repeat (2) idle(1'b1, 1'b0);

    // Eight random back-to-back sets with a mid-stream stall
    collect = 1'b1;
    got     = 0;
    for (int i = 0; i < 8; i++) begin
      a = rnd8(); b = rnd8(); c = rnd8();
      m = 3'($urandom_range(0, 7));
      sb_s.push_back(sat8((m[0] ? -a : a) + (m[1] ? -b : b) + (m[2] ? -c : c)));
      sb_w.push_back(wrap8((m[0] ? -a : a) + (m[1] ? -b : b) + (m[2] ? -c : c)));
      step(1'b1, 1'b1, 1'b1, a, b, c, m, 1'b0);
      if (i == 3) begin
        repeat (3) step(1'b1, 1'b0, 1'b1, rnd8(), rnd8(), rnd8(), 3'b000, 1'b0);
      end
    end
    repeat (8) idle(1'b1, 1'b0);
    collect = 1'b0;
    chk("random_result_count", got, 8);

    // Reset with sets in flight
    idle(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 100, 50, -20, 3'b000, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    chk("pre_reset_ovf", int'(of_s), 1);
    step(1'b1, 1'b1, 1'b1, 1, 2, 3, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4, 5, 6, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7, 8, 9, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 10, 10, 10, 3'b000, 1'b0);
    chk("midrst_y", int'(y_s), 0);
    chk("midrst_out_valid", int'(ov_s), 0);
    chk("midrst_ovf", int'(of_s), 0);
    collect = 1'b1;
    got     = 0;
    repeat (6) idle(1'b1, 1'b0);
    collect = 1'b0;
    chk("no_stale_result", got, 0);

    // Overflow set and clr_ovf in the same cycle
    step(1'b1, 1'b1, 1'b1, 100, 50, -20, 3'b000, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("set_beats_clr", int'(of_s), 1);
    idle(1'b0, 1'b1);
    chk("clr_while_stalled", int'(of_s), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
